// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
// MC_ILLEGAL_TRAP_EN adds the sticky TRAP state.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_LUI      = 4'd8,
    S_AUIPC    = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11,
    S_JAL      = 4'd12,
    S_JALR_ADR = 4'd13,
`ifdef MC_ILLEGAL_TRAP_EN
    S_JALR     = 4'd14,
    S_TRAP     = 4'd15
`else
    S_JALR     = 4'd14
`endif
  } mc_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_JALR = 3'b101;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [2:0] MODE_NONE  = 3'b000;
  localparam logic [2:0] MODE_WORD  = 3'b001;
  localparam logic [2:0] MODE_HALF  = 3'b010;
  localparam logic [2:0] MODE_BYTE  = 3'b011;
  localparam logic [2:0] MODE_HALFU = 3'b100;
  localparam logic [2:0] MODE_BYTEU = 3'b101;

  function automatic logic is_mem_state(input mc_state_e s);
    return (s == S_MEMADR) || (s == S_MEMRD) || (s == S_MEMWB) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ls_mode_decoder.sv
// Immediate-format and load/store width decode from opcode and funct3.
// Width mode is only reported while the sequencer is in a memory state.
module ls_mode_decoder
  import mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       mem_phase_i,
  output logic [2:0] imm_src_o,
  output logic [2:0] mode_bu_o
);

  always_comb begin
    imm_src_o = IMM_NONE;
    case (opcode_i)
      OP_LOAD, OP_I:    imm_src_o = IMM_I;
      OP_STORE:         imm_src_o = IMM_S;
      OP_BRANCH:        imm_src_o = IMM_B;
      OP_LUI, OP_AUIPC: imm_src_o = IMM_U;
      OP_JAL:           imm_src_o = IMM_J;
      OP_JALR:          imm_src_o = IMM_JALR;
      default:          imm_src_o = IMM_NONE;
    endcase
  end

  // Unsigned variants exist only for loads; a bad funct3 yields NONE and the access still runs.
  always_comb begin
    mode_bu_o = MODE_NONE;
    if (mem_phase_i && opcode_i == OP_LOAD) begin
      case (funct3_i)
        3'b000:  mode_bu_o = MODE_BYTE;
        3'b001:  mode_bu_o = MODE_HALF;
        3'b010:  mode_bu_o = MODE_WORD;
        3'b100:  mode_bu_o = MODE_BYTEU;
        3'b101:  mode_bu_o = MODE_HALFU;
        default: mode_bu_o = MODE_NONE;
      endcase
    end else if (mem_phase_i && opcode_i == OP_STORE) begin
      case (funct3_i)
        3'b000:  mode_bu_o = MODE_BYTE;
        3'b001:  mode_bu_o = MODE_HALF;
        3'b010:  mode_bu_o = MODE_WORD;
        default: mode_bu_o = MODE_NONE;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Per-instruction sequencer for the multi-cycle RV32I datapath.
// Define MC_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        mem_ready,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic [2:0]  modeBU,
  output logic        instr_retire,
  output logic        trap,
  output mc_state_e   dbg_state_o
);

  // Memory handshake: MemRead/MemWrite are held steady while mem_ready is low;
  // the access completes in the cycle mem_ready is high and the FSM advances on that edge.
  mc_state_e state_q, state_d;
  logic pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c, retire_c;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = Instr[6:0];
  assign funct3            = Instr[14:12];
  assign unused_instr_bits = ^{Instr[31:15], Instr[11:7]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    retire_c    = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_FOUR;
    ResultSrc   = RES_ALURESULT;
    ALUOp       = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef MC_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default: begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_READDATA;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc      = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc   = RES_ALUOUT;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_BRANCH;
        ResultSrc  = RES_ALUOUT;
        pc_write_c = BranchTaken;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      // Jump target was latched into ALUOut during DECODE/JALR_ADR; the ALU now forms OldPC+4.
      S_JAL, S_JALR: begin
        pc_write_c = 1'b1;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        state_d    = S_ALUWB;
      end
      S_JALR_ADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = S_JALR;
      end
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Reset kills every strobe combinationally so an aborted instruction writes nothing.
  assign PCWrite      = pc_write_c  & ~rst;
  assign IRWrite      = ir_write_c  & ~rst;
  assign RegWrite     = reg_write_c & ~rst;
  assign MemRead      = mem_read_c  & ~rst;
  assign MemWrite     = mem_write_c & ~rst;
  assign instr_retire = retire_c    & ~rst;
  assign dbg_state_o  = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP);
`else
  assign trap = 1'b0;
`endif

  ls_mode_decoder u_ls_mode_decoder (
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .mem_phase_i (is_mem_state(state_q)),
    .imm_src_o   (ImmSrc),
    .mode_bu_o   (modeBU)
  );

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing FSM for the multi-cycle RV32I datapath. It replaces the single-cycle control decode with a per-instruction state machine that drives one shared memory port, one ALU and the register file over several cycles. It stalls on a memory ready handshake and produces register, PC and IR write strobes, mux selects, ALUOp, ImmSrc and the load/store width mode. ALUOp feeds the existing ALUDecoder in the datapath.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- Instr  in  32  contents of the instruction register (valid from DECODE onward)
- mem_ready  in  1  memory completed the current read/write this cycle
- BranchTaken  in  1  branch comparison result for current B-type funct3
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite  out  1 each  strobes
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
- ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
- ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 I-jalr, 111 none
- modeBU  out  3  011 byte, 010 half, 001 word, 101 byte unsigned, 100 half unsigned, 000 none
- instr_retire  out  1  one-cycle pulse in the final cycle of every instruction
- trap  out  1  sticky illegal-instruction flag (MC_ILLEGAL_TRAP_EN only, else tied 0)

## Operation
- Outputs are a Moore decode of the state, except where gated by mem_ready or BranchTaken as noted. ImmSrc and modeBU are decoded from Instr in every state.
- FETCH: AdrSrc=0, MemRead=1. When mem_ready=1, also assert IRWrite=1, PCWrite=1 (ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10) and go to DECODE. Otherwise hold.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This precomputes OldPC+imm. Dispatch on opcode:
  - 0000011 and 0100011 → MEMADR
  - 0110011 → EXEC_R; 0010011 → EXEC_I
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR_ADR
  - 0110111 → LUI; 0010111 → AUIPC
  - any other opcode → illegal path (see Configuration)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMRD for loads, MEMWR for stores.
- MEMRD: AdrSrc=1, MemRead=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire → FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, held until mem_ready; then retire → FETCH.
- EXEC_R: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXEC_I: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00 → ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire → FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=BranchTaken; retire → FETCH.
- JAL: PCWrite=1 with ResultSrc=00 (target from DECODE). ALUSrcA=01, ALUSrcB=10 form the link value → ALUWB.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 → JALR.
- JALR: identical outputs to JAL → ALUWB.
- modeBU is non-zero only in MEMADR, MEMRD, MEMWB and MEMWR. An invalid funct3 gives 000, and the access proceeds.

## Timing
- Reset: state=FETCH, trap=0. While rst is high, all strobes and instr_retire are forced to 0. Selects take their FETCH values.
- Cycle counts with zero-wait memory (mem_ready=1):
  - R, I, LUI, AUIPC: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
  - JAL: 4 cycles; JALR: 5 cycles
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes are held stable through the wait.
- mem_ready is ignored in every other state.
- Reset asserted mid-instruction aborts it immediately with no partial write. Fetch restarts on the first clock after rst deasserts.

## Configuration
- MC_ILLEGAL_TRAP_EN defined: an illegal opcode goes DECODE → TRAP.
  - TRAP has all strobes 0, trap=1, no retire.
  - TRAP is left only by reset.
- Not defined: an illegal opcode is treated as a NOP. DECODE asserts instr_retire and returns to FETCH. trap is constant 0 and the TRAP state does not exist.

## Structure
- Package mc_pkg holds:
  - state enum
  - opcode constants
  - ALUSrcA/ALUSrcB/ResultSrc/ALUOp/ImmSrc/modeBU encodings
- Sub-module ls_mode_decoder maps opcode and funct3 to ImmSrc and modeBU (combinational). It is instantiated once.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALUWB. RegWrite=1 only in cycle 4; instr_retire pulses in cycle 4.
- lw x5,8(x1) (0x0080A283), mem_ready held low 2 cycles in MEMRD → MemRead/AdrSrc=1 stable for 3 cycles. modeBU=001. RegWrite with ResultSrc=01 after exactly 7 cycles.
- sb (funct3 000), then lhu (funct3 101) → modeBU=011 in MEMWR, then 100 in MEMRD. MemWrite deasserts the cycle after mem_ready.
- beq with BranchTaken=0, then with BranchTaken=1 → PCWrite=0, then 1 in the BRANCH cycle. Both take 3 cycles.
- jalr x1,0(x2) → states JALR_ADR then JALR. PCWrite=1 in JALR, RegWrite=1 in ALUWB, 5 cycles total.
- Opcode 0x7F: with the macro, trap=1 and no strobes persist until rst. Without it, retire in DECODE, then FETCH. rst pulsed in MEMRD → next cycle FETCH with all strobes 0.
